// File: rtl/red_seq.sv
// red_seq: multi-cycle lane reduction unit.
// Splits two DATA_W sources into LANE_W-bit lanes and sums all 2*NL lanes,
// one lane pair per cycle, then formats the sum per the latched mode
// (legacy RED, unsigned, signed, signed-saturate).
//
// Handshake: i_start is sampled only on an edge where o_busy==0. An accepted
// request keeps o_busy high for NL cycles; o_done then pulses for exactly one
// cycle with o_rd newly valid. o_busy is low during the o_done cycle, so a
// start presented there is accepted (one op every NL+1 cycles). Operand and
// mode changes while busy are ignored because captured copies are used.
module red_seq #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_dbg_state
);

    localparam int NL       = DATA_W / LANE_W;
    localparam int ACC_W    = LANE_W + $clog2(2 * NL) + 1;
    localparam int IDX_W    = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NL - 1);

    // Saturation window for mode 11: [-2^(LANE_W-1), 2^(LANE_W-1)-1].
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (LANE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [1:0] MODE_LEGACY   = 2'b00;
    localparam logic [1:0] MODE_UNSIGNED = 2'b01;
    localparam logic [1:0] MODE_SIGNED   = 2'b10;
    localparam logic [1:0] MODE_SAT      = 2'b11;

    // Parameter sanity, caught at elaboration.
    if (DATA_W % LANE_W != 0) begin : g_bad_lane_div
        $error("red_seq: DATA_W must be a multiple of LANE_W");
    end
    if (LANE_W < 2) begin : g_bad_lane_w
        $error("red_seq: LANE_W must be at least 2");
    end
    if (ACC_W > DATA_W + 1) begin : g_bad_acc_w
        $error("red_seq: accumulator wider than DATA_W+1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DATA_W-1:0]  r_rs;
    logic [DATA_W-1:0]  r_rt;
    logic [1:0]         r_mode;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [DATA_W-1:0]  r_rd;

    logic               w_capture;
    logic               w_step;
    logic               w_last;
    logic               w_busy;

    logic [LANE_W-1:0]  w_lane_a;
    logic [LANE_W-1:0]  w_lane_b;
    logic               w_sign_mode;
    logic [ACC_W-1:0]   w_ext_a;
    logic [ACC_W-1:0]   w_ext_b;
    logic [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0] w_sum_s;
    logic signed [ACC_W-1:0] w_sat;
    logic [DATA_W-1:0]  w_result;

    // State register: rst returns to IDLE from anywhere, aborting any op.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> IDLE on the last lane.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_last    = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_capture = i_start;
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                w_last = (r_idx == LAST_IDX);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Lane pair selection and extension for the shared adder.
    always_comb begin
        w_lane_a    = LANE_W'(r_rs >> (r_idx * LANE_W));
        w_lane_b    = LANE_W'(r_rt >> (r_idx * LANE_W));
        w_sign_mode = r_mode[1];
        w_ext_a     = {{(ACC_W - LANE_W){w_sign_mode & w_lane_a[LANE_W-1]}}, w_lane_a};
        w_ext_b     = {{(ACC_W - LANE_W){w_sign_mode & w_lane_b[LANE_W-1]}}, w_lane_b};
        // ACC_W covers the worst case of all lanes, so this never wraps.
        w_sum       = r_acc + w_ext_a + w_ext_b;
        w_sum_s     = w_sum;
    end

    // Result formatting of the full-precision sum according to the latched mode.
    always_comb begin
        w_sat    = w_sum_s;
        w_result = '0;
        if (w_sum_s > SAT_MAX) begin
            w_sat = SAT_MAX;
        end else if (w_sum_s < SAT_MIN) begin
            w_sat = SAT_MIN;
        end
        case (r_mode)
            // Legacy RED keeps LANE_W+1 bits and treats them as signed.
            MODE_LEGACY:   w_result = DATA_W'($signed(w_sum[LANE_W:0]));
            MODE_UNSIGNED: w_result = DATA_W'(w_sum);
            MODE_SIGNED:   w_result = DATA_W'(w_sum_s);
            MODE_SAT:      w_result = DATA_W'(w_sat);
            default:       w_result = '0;
        endcase
    end

    // Datapath: capture operands on accept, accumulate per lane, register result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rs   <= '0;
            r_rt   <= '0;
            r_mode <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_rd   <= '0;
        end else begin
            r_done <= w_last;
            if (w_capture) begin
                r_rs   <= i_rs;
                r_rt   <= i_rt;
                r_mode <= i_mode;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (w_step) begin
                r_acc  <= w_sum;
                r_idx  <= r_idx + 1'b1;
            end
            if (w_last) begin
                r_rd <= w_result;
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = r_done;
    assign o_rd        = r_rd;
    assign o_dbg_state = r_state;

endmodule
